window_generator_3x3: RTL and testbench

WINDOW_GENERATOR_3X3 -- requirements
Module: window_generator_3x3

---
 rtl/window_generator_3x3.sv | 131 +++++++++++++
 tb/tb_window_generator_3x3.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_generator_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Emits only fully-interior windows, one cycle after the pixel that completes each one.
module window_generator_3x3 #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        frame_start,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic [71:0] window_data,
    output logic        window_valid,
    output logic [7:0]  window_x,
    output logic [7:0]  window_y,
    output logic        frame_done
);
    localparam int         COL_W    = $clog2(IMG_WIDTH);
    localparam logic [7:0] LAST_COL = 8'(IMG_WIDTH - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

    state_t      state_q, state_d, cur_state;
    logic [7:0]  col_q, col_d, row_q, row_d, cur_col, cur_row;
    logic        accept, last_col, emit;
    logic [COL_W-1:0] col_idx;
    logic [7:0]  lb1_rd, lb2_rd;
    logic [7:0]  linebuf1_q [IMG_WIDTH];
    logic [7:0]  linebuf2_q [IMG_WIDTH];
    logic [7:0]  win_q [3][3];
    logic [7:0]  win_d [3][3];
    logic [71:0] window_data_q, window_data_d;
    logic        window_valid_q, window_valid_d;
    logic [7:0]  window_x_q, window_x_d, window_y_q, window_y_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        // frame_start overrides the stored position so the pixel arriving with it is (0,0)
        cur_state = frame_start ? FILL : state_q;
        cur_col   = frame_start ? 8'd0 : col_q;
        cur_row   = frame_start ? 8'd0 : row_q;
        accept    = pixel_in_valid && (cur_state != IDLE);
        last_col  = (cur_col == LAST_COL);
        emit      = accept && (cur_row >= 8'd2) && (cur_col >= 8'd2);
        col_idx   = cur_col[COL_W-1:0];
        lb1_rd    = linebuf1_q[col_idx];
        lb2_rd    = linebuf2_q[col_idx];

        state_d      = cur_state;
        col_d        = cur_col;
        row_d        = cur_row;
        frame_done_d = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end

        if (accept) begin
            col_d = last_col ? 8'd0 : cur_col + 8'd1;
            row_d = last_col ? cur_row + 8'd1 : cur_row;
            if (cur_state == FILL && last_col && cur_row == 8'd1) begin
                state_d = ACTIVE;
            end
            if (cur_state == ACTIVE && last_col && cur_row == LAST_ROW) begin
                state_d      = IDLE;
                row_d        = 8'd0;
                frame_done_d = 1'b1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = pixel_in;
        end

        window_valid_d = emit;
        window_data_d  = window_data_q;
        window_x_d     = window_x_q;
        window_y_d     = window_y_q;
        if (emit) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    window_data_d[(3*r + c)*8 +: 8] = win_d[r][c];
                end
            end
            window_x_d = cur_col - 8'd1;
            window_y_d = cur_row - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q        <= IDLE;
            col_q          <= 8'd0;
            row_q          <= 8'd0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            window_data_q  <= 72'd0;
            window_x_q     <= 8'd0;
            window_y_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            window_data_q  <= window_data_d;
            window_x_q     <= window_x_d;
            window_y_q     <= window_y_d;
        end
    end

    // Buffer and window contents are never emitted until refilled by the current frame
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1_q[col_idx] <= pixel_in;
            linebuf2_q[col_idx] <= lb1_rd;
        end
        win_q <= win_d;
    end

    assign window_data  = window_data_q;
    assign window_valid = window_valid_q;
    assign window_x     = window_x_q;
    assign window_y     = window_y_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_window_generator_3x3.sv
// Directed bench for window_generator_3x3: a 4x4 instance with a scoreboard of
// expected windows, and a 256x3 instance checked against a ramp image.
module tb_window_generator_3x3;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] d;
        logic [7:0]  x;
        logic [7:0]  y;
    } win_t;

    logic        clk, rstN;
    logic        frame_start, pixel_in_valid;
    logic [7:0]  pixel_in;
    logic [71:0] window_data;
    logic        window_valid, frame_done;
    logic [7:0]  window_x, window_y;

    logic        b_fs, b_vld;
    logic [7:0]  b_pix;
    logic [71:0] b_wd;
    logic        b_wv, b_done;
    logic [7:0]  b_wx, b_wy;

    window_generator_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rstN(rstN), .frame_start(frame_start), .pixel_in(pixel_in),
        .pixel_in_valid(pixel_in_valid), .window_data(window_data),
        .window_valid(window_valid), .window_x(window_x), .window_y(window_y),
        .frame_done(frame_done)
    );

    window_generator_3x3 #(.IMG_WIDTH(256), .IMG_HEIGHT(3)) dut_wide (
        .clk(clk), .rstN(rstN), .frame_start(b_fs), .pixel_in(b_pix),
        .pixel_in_valid(b_vld), .window_data(b_wd), .window_valid(b_wv),
        .window_x(b_wx), .window_y(b_wy), .frame_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    win_t        exp_q[$];
    logic [7:0]  img [H][W];
    bit          m_on;
    int          m_row, m_col;
    logic        exp_done_drv;
    int          a_wins, a_dones, b_wins, b_dones;
    bit          cap_first, alt_mode;
    logic [71:0] first_wd, last_pop;
    logic [7:0]  first_x, first_y, b_last_x;
    int          w0, d0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle of stimulus for the 4x4 instance; the model pushes the window this pixel completes.
    task automatic step(input logic fs, input logic vld, input logic [7:0] val, input logic rst_n);
        logic [71:0] d;
        @(posedge clk);
        #1;
        rstN           = rst_n;
        frame_start    = fs;
        pixel_in_valid = vld;
        pixel_in       = val;
        exp_done_drv   = 1'b0;
        if (!rst_n) begin
            m_on = 0; m_row = 0; m_col = 0;
        end else begin
            if (fs) begin
                m_on = 1; m_row = 0; m_col = 0;
            end
            if (vld && m_on) begin
                img[m_row][m_col] = val;
                if (m_row >= 2 && m_col >= 2) begin
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            d[(3*rr + cc)*8 +: 8] = img[m_row-2+rr][m_col-2+cc];
                    exp_q.push_back('{d: d, x: 8'(m_col - 1), y: 8'(m_row - 1)});
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    if (m_row == H - 1) begin
                        m_on = 0; m_row = 0; exp_done_drv = 1'b1;
                    end else begin
                        m_row++;
                    end
                end else begin
                    m_col++;
                end
            end
        end
    endtask

    task automatic frame_a(input bit ff, input bit alt);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step((r == 0 && c == 0), 1'b1, ff ? 8'hFF : 8'(16*r + c), 1'b1);
                if (alt) step(1'b0, 1'b0, 8'h00, 1'b1);
            end
        end
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic stepb(input logic fs, input logic vld, input logic [7:0] val);
        @(posedge clk);
        #1;
        b_fs = fs; b_vld = vld; b_pix = val;
    endtask

    initial begin
        rstN = 1'b0; frame_start = 1'b0; pixel_in_valid = 1'b0; pixel_in = 8'h00;
        b_fs = 1'b0; b_vld = 1'b0; b_pix = 8'h00;
        exp_done_drv = 1'b0; m_on = 0; m_row = 0; m_col = 0;
        a_wins = 0; a_dones = 0; b_wins = 0; b_dones = 0;
        cap_first = 0; alt_mode = 0; first_wd = '0; last_pop = '0;
        first_x = '0; first_y = '0; b_last_x = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_window_valid", 72'(window_valid), 72'd0);
        check("rst_frame_done", 72'(frame_done), 72'd0);
        check("rst_window_data", window_data, 72'd0);
        check("rst_window_x", 72'(window_x), 72'd0);
        check("rst_window_y", 72'(window_y), 72'd0);
        check("rst_b_window_valid", 72'(b_wv), 72'd0);

        fork
            begin : mon_a
                logic rs, ed, prev_wv;
                logic [71:0] last_wd;
                win_t e;
                prev_wv = 1'b0;
                last_wd = '0;
                forever begin
                    @(posedge clk);
                    rs = !rstN;
                    ed = exp_done_drv;
                    @(negedge clk);
                    if (window_valid === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_window", 72'(window_valid), 72'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("window_data", window_data, e.d);
                            check("window_x", 72'(window_x), 72'(e.x));
                            check("window_y", 72'(window_y), 72'(e.y));
                            a_wins++;
                            last_pop = window_data;
                            if (cap_first) begin
                                first_wd = window_data; first_x = window_x; first_y = window_y;
                                cap_first = 0;
                            end
                        end
                        last_wd = window_data;
                    end else begin
                        check("window_valid_low", 72'(window_valid), 72'd0);
                        check("data_hold", window_data, rs ? 72'd0 : last_wd);
                        if (rs) last_wd = '0;
                    end
                    if (frame_done === 1'b1) a_dones++;
                    check("frame_done", 72'(frame_done), 72'(ed));
                    if (alt_mode) check("no_back_to_back", 72'(window_valid & prev_wv), 72'd0);
                    prev_wv = window_valid;
                end
            end
            begin : mon_b
                logic [71:0] bd;
                forever begin
                    @(negedge clk);
                    if (b_wv === 1'b1) begin
                        b_wins++;
                        for (int rr = 0; rr < 3; rr++)
                            for (int cc = 0; cc < 3; cc++)
                                bd[(3*rr + cc)*8 +: 8] = 8'(int'(b_wx) - 1 + cc + 7*rr);
                        check("b_window_x", 72'(b_wx), 72'(b_wins));
                        check("b_window_y", 72'(b_wy), 72'd1);
                        check("b_window_data", b_wd, bd);
                        b_last_x = b_wx;
                    end
                    if (b_done === 1'b1) b_dones++;
                end
            end
        join_none

        // Back-to-back frame
        w0 = a_wins; d0 = a_dones; cap_first = 1;
        frame_a(1'b0, 1'b0);
        check("t1_first_data", first_wd, 72'h22_21_20_12_11_10_02_01_00);
        check("t1_first_x", 72'(first_x), 72'd1);
        check("t1_first_y", 72'(first_y), 72'd1);
        check("t1_windows", 72'(a_wins - w0), 72'd4);
        check("t1_frame_done", 72'(a_dones - d0), 72'd1);
        check("t1_queue_empty", 72'(exp_q.size()), 72'd0);

        // Alternate-cycle valid
        w0 = a_wins; d0 = a_dones; alt_mode = 1;
        frame_a(1'b0, 1'b1);
        alt_mode = 0;
        check("t2_windows", 72'(a_wins - w0), 72'd4);
        check("t2_frame_done", 72'(a_dones - d0), 72'd1);
        check("t2_queue_empty", 72'(exp_q.size()), 72'd0);

        // Pixels without frame_start after reset
        w0 = a_wins; d0 = a_dones;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i + 3), 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1);
        check("t3_windows", 72'(a_wins - w0), 72'd0);
        check("t3_frame_done", 72'(a_dones - d0), 72'd0);
        check("t3_window_x", 72'(window_x), 72'd0);
        check("t3_window_y", 72'(window_y), 72'd0);

        // frame_start reasserted at pixel (2,1), then an all-0xFF frame
        w0 = a_wins; d0 = a_dones;
        for (int i = 0; i < 9; i++) step(i == 0, 1'b1, 8'(16*(i/4) + i%4), 1'b1);
        frame_a(1'b1, 1'b0);
        check("t4_windows", 72'(a_wins - w0), 72'd4);
        check("t4_frame_done", 72'(a_dones - d0), 72'd1);
        check("t4_last_ff", last_pop, {9{8'hFF}});
        check("t4_queue_empty", 72'(exp_q.size()), 72'd0);

        // Reset at pixel (2,3), stray pixels while idle, then a clean frame
        w0 = a_wins; d0 = a_dones;
        for (int i = 0; i < 11; i++) step(i == 0, 1'b1, 8'(16*(i/4) + i%4), 1'b1);
        step(1'b0, 1'b1, 8'h23, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h30 + 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("t5_after_reset_windows", 72'(a_wins - w0), 72'd1);
        frame_a(1'b0, 1'b0);
        check("t5_windows", 72'(a_wins - w0), 72'd5);
        check("t5_frame_done", 72'(a_dones - d0), 72'd1);
        check("t5_queue_empty", 72'(exp_q.size()), 72'd0);

        // 256x3 ramp frame on the wide instance
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 256; c++)
                stepb((r == 0 && c == 0), 1'b1, 8'(c + 7*r));
        repeat (3) stepb(1'b0, 1'b0, 8'h00);
        check("b_windows", 72'(b_wins), 72'd254);
        check("b_last_x", 72'(b_last_x), 72'd254);
        check("b_frame_done", 72'(b_dones), 72'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
